// File: rtl/bram_port_ctrl_pkg.sv
// Shared types and constants for the BRAM port controller.
// Provides the controller state encoding and byte-lane width.
package bram_port_ctrl_pkg;

    localparam int unsigned BYTE_W = 8;

    // IDLE accepts requests; RMW_MERGE issues the merged write of a partial store.
    typedef enum logic {
        S_IDLE      = 1'b0,
        S_RMW_MERGE = 1'b1
    } state_e;

endpackage

// File: rtl/bram_port_ctrl_resp_fifo.sv
// Response FIFO holding BRAM read data until the consumer accepts it.
// Ports: clk_i/rst_i (sync active-high), push_i/push_data_i, pop_i,
//        head_o (oldest entry), count_o (occupancy), empty_o.
module bram_port_ctrl_resp_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2,
    localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [CNT_W-1:0]      count_o,
    output logic                  empty_o
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_do_pop;

    // Wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_do_pop = pop_i && (r_count != '0);
    assign head_o   = r_mem[r_rd_ptr];
    assign count_o  = r_count;
    assign empty_o  = (r_count == '0);

    // Pointer and occupancy tracking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i)   r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({push_i, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by r_count.
    always_ff @(posedge clk_i) begin
        if (push_i) r_mem[r_wr_ptr] <= push_data_i;
    end

endmodule

// File: rtl/bram_port_ctrl.sv
// Initiator for a single-port BRAM with 1-cycle registered read.
// Converts a valid/ready request stream (read, full write, byte-strobed
// write via read-modify-write) into BRAM commands and returns read data
// on a valid/ready response stream, strictly in request order.
// Ports: clk_i, rst_i (sync active-high); req_* request channel;
//        resp_* response channel; bram_* BRAM command/data interface.
module bram_port_ctrl
    import bram_port_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned BRAM_DEPTH  = 128,
    parameter int unsigned RESP_DEPTH  = 2,
    localparam int unsigned ADDR_WIDTH = $clog2(BRAM_DEPTH),
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / BYTE_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [STRB_WIDTH-1:0] req_wstrb_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  bram_cmd_en_o,
    output logic                  bram_wr_en_o,
    output logic [ADDR_WIDTH-1:0] bram_addr_o,
    output logic [DATA_WIDTH-1:0] bram_data_o,
    input  logic [DATA_WIDTH-1:0] bram_data_i
);

    localparam int unsigned CNT_W  = $clog2(RESP_DEPTH + 1);
    localparam int unsigned USED_W = CNT_W + 1;

    state_e                r_state;
    state_e                w_state_nxt;
    logic                  r_inflight;
    logic [ADDR_WIDTH-1:0] r_rmw_addr;
    logic [DATA_WIDTH-1:0] r_rmw_wdata;
    logic [STRB_WIDTH-1:0] r_rmw_strb;
    logic [CNT_W-1:0]      w_count;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_accept;
    logic [USED_W-1:0]     w_used;
    logic                  w_strb_full;
    logic                  w_strb_zero;
    logic [DATA_WIDTH-1:0] w_merge;

    assign w_strb_full  = &req_wstrb_i;
    assign w_strb_zero  = ~|req_wstrb_i;
    assign resp_valid_o = !rst_i && !w_empty;
    assign w_pop        = resp_valid_o && resp_ready_i;

    // Credits: FIFO entries plus the read in flight, less the entry leaving
    // this cycle, so a full-rate read stream never stalls with RESP_DEPTH=2.
    assign w_used      = USED_W'(w_count) + USED_W'(r_inflight) - USED_W'(w_pop);
    assign req_ready_o = !rst_i && (r_state == S_IDLE) && (w_used < USED_W'(RESP_DEPTH));
    assign w_accept    = req_valid_i && req_ready_o;

    // Byte merge of latched store data over the freshly read BRAM word.
    always_comb begin
        w_merge = bram_data_i;
        for (int b = 0; b < int'(STRB_WIDTH); b++) begin
            if (r_rmw_strb[b]) w_merge[b*BYTE_W +: BYTE_W] = r_rmw_wdata[b*BYTE_W +: BYTE_W];
        end
    end

    // Next state and combinational BRAM command mux.
    always_comb begin
        w_state_nxt   = r_state;
        bram_cmd_en_o = 1'b0;
        bram_wr_en_o  = 1'b0;
        bram_addr_o   = req_addr_i;
        bram_data_o   = req_wdata_i;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    bram_cmd_en_o = !req_we_i || !w_strb_zero;
                    bram_wr_en_o  = req_we_i && w_strb_full;
                    if (req_we_i && !w_strb_full && !w_strb_zero) w_state_nxt = S_RMW_MERGE;
                end
            end
            S_RMW_MERGE: begin
                bram_cmd_en_o = 1'b1;
                bram_wr_en_o  = 1'b1;
                bram_addr_o   = r_rmw_addr;
                bram_data_o   = w_merge;
                w_state_nxt   = S_IDLE;
            end
        endcase
        // A pending merge write is abandoned when reset lands on it.
        if (rst_i) begin
            bram_cmd_en_o = 1'b0;
            bram_wr_en_o  = 1'b0;
        end
    end

    // State and read-in-flight tracking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_accept && !req_we_i;
        end
    end

    // Partial-store operands held for the merge cycle.
    always_ff @(posedge clk_i) begin
        if (w_accept && req_we_i) begin
            r_rmw_addr  <= req_addr_i;
            r_rmw_wdata <= req_wdata_i;
            r_rmw_strb  <= req_wstrb_i;
        end
    end

    // Read data is captured the cycle after the read command.
    bram_port_ctrl_resp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RESP_DEPTH)
    ) u_resp_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (r_inflight),
        .push_data_i (bram_data_i),
        .pop_i       (w_pop),
        .head_o      (resp_rdata_o),
        .count_o     (w_count),
        .empty_o     (w_empty)
    );

endmodule

// File: tb/tb_bram_port_ctrl.sv
// Bench for bram_port_ctrl with a behavioural BRAM and a reference model.
module tb_bram_port_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 128;
    localparam int AW    = 7;
    localparam int SW    = 4;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_wstrb;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata;
    logic          bram_cmd_en;
    logic          bram_wr_en;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wdata;
    logic [DW-1:0] bram_rdata;

    bram_port_ctrl #(.DATA_WIDTH(DW), .BRAM_DEPTH(DEPTH), .RESP_DEPTH(2)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_we_i      (req_we),
        .req_addr_i    (req_addr),
        .req_wdata_i   (req_wdata),
        .req_wstrb_i   (req_wstrb),
        .resp_valid_o  (resp_valid),
        .resp_ready_i  (resp_ready),
        .resp_rdata_o  (resp_rdata),
        .bram_cmd_en_o (bram_cmd_en),
        .bram_wr_en_o  (bram_wr_en),
        .bram_addr_o   (bram_addr),
        .bram_data_o   (bram_wdata),
        .bram_data_i   (bram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural BRAM; read data is junk except the cycle after a read.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] bram_q;
    logic          bram_q_vld;
    logic          mem_init;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hC0DE0000 | DW'(i);
            bram_q_vld <= 1'b0;
            bram_q     <= '0;
        end else begin
            bram_q_vld <= bram_cmd_en && !bram_wr_en;
            if (bram_cmd_en) begin
                if (bram_wr_en) mem[bram_addr] <= bram_wdata;
                else            bram_q <= mem[bram_addr];
            end
        end
    end
    assign bram_rdata = bram_q_vld ? bram_q : 32'hBAD0BAD0;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    int            total;
    int            bad;
    int            cyc;
    int            n_cmd;
    int            n_rd_acc;
    int            last_rd_acc;
    int            pop_cyc[$];
    logic [DW-1:0] pop_dat[$];
    logic [DW-1:0] refm [DEPTH];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [SW-1:0] s);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < SW; b++) if (s[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    // Reference model: memory image plus a queue of expected responses,
    // each becoming visible two cycles after its read was accepted.
    task automatic monitor();
        exp_t          q[$];
        exp_t          e;
        logic          pend;
        logic          was_pend;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        logic [SW-1:0] ps;
        logic          acc;
        logic          exp_cmd;
        logic          exp_wr;
        logic          exp_vld;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                chk("rst_req_ready", 32'(req_ready), 0);
                chk("rst_resp_valid", 32'(resp_valid), 0);
                chk("rst_cmd_en", 32'(bram_cmd_en), 0);
                chk("rst_wr_en", 32'(bram_wr_en), 0);
                q.delete();
                pend = 1'b0;
            end else begin
                acc      = req_valid && req_ready;
                was_pend = pend;
                exp_cmd  = pend || (acc && (!req_we || req_wstrb != '0));
                exp_wr   = pend || (acc && req_we && req_wstrb == 4'hF);
                chk("cmd_en", 32'(bram_cmd_en), 32'(exp_cmd));
                chk("wr_en", 32'(bram_wr_en), 32'(exp_wr));
                if (bram_cmd_en) n_cmd++;
                if (was_pend) begin
                    chk("rmw_ready", 32'(req_ready), 0);
                    chk("rmw_addr", 32'(bram_addr), 32'(pa));
                    chk("rmw_data", bram_wdata, merge(refm[pa], pd, ps));
                    refm[pa] = merge(refm[pa], pd, ps);
                    pend = 1'b0;
                end else if (acc && exp_cmd) begin
                    chk("cmd_addr", 32'(bram_addr), 32'(req_addr));
                    if (exp_wr) chk("cmd_wdata", bram_wdata, req_wdata);
                end
                exp_vld = (q.size() > 0) && (q[0].due <= cyc);
                chk("resp_valid", 32'(resp_valid), 32'(exp_vld));
                if (resp_valid && q.size() > 0) begin
                    chk("resp_data", resp_rdata, q[0].data);
                    if (resp_ready) begin
                        pop_cyc.push_back(cyc);
                        pop_dat.push_back(resp_rdata);
                        void'(q.pop_front());
                    end
                end
                if (acc) begin
                    if (!req_we) begin
                        e.data = refm[req_addr];
                        e.due  = cyc + 2;
                        q.push_back(e);
                        n_rd_acc++;
                        last_rd_acc = cyc;
                    end else if (req_wstrb == 4'hF) begin
                        refm[req_addr] = req_wdata;
                    end else if (req_wstrb != '0) begin
                        pend = 1'b1;
                        pa   = req_addr;
                        pd   = req_wdata;
                        ps   = req_wstrb;
                    end
                end
            end
        end
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    // Present one request and hold it until accepted (bounded).
    task automatic req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s);
        int n;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready) begin
            chk("req_timeout", 32'(req_ready), 1);
            req_valid = 1'b0;
            to_drive();
        end else begin
            to_drive();
            req_valid = 1'b0;
        end
    endtask

    int n0;

    initial begin
        total = 0; bad = 0; cyc = 0; n_cmd = 0; n_rd_acc = 0; last_rd_acc = 0;
        rst = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) refm[i] = 32'hC0DE0000 | DW'(i);
        fork
            monitor();
        join_none

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("in_reset_ready", 32'(req_ready), 0);
        mem_init = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", 32'(req_ready), 1);
        chk("post_reset_valid", 32'(resp_valid), 0);
        to_drive();

        // 1: full write then read, latency 2
        pop_cyc.delete(); pop_dat.delete();
        req(1'b1, 7'd5, 32'hDEADBEEF, 4'hF);
        req(1'b0, 7'd5, 32'h0, 4'h0);
        repeat (4) @(negedge clk);
        chk("t1_count", 32'(pop_cyc.size()), 1);
        if (pop_cyc.size() > 0) begin
            chk("t1_data", pop_dat[0], 32'hDEADBEEF);
            chk("t1_latency", 32'(pop_cyc[0] - last_rd_acc), 2);
        end
        to_drive();

        // 2: byte-strobed write through read-modify-write
        req(1'b1, 7'd3, 32'h11223344, 4'hF);
        req(1'b1, 7'd3, 32'hAABBCCDD, 4'b0101);
        @(negedge clk);
        chk("t2_ready_low", 32'(req_ready), 0);
        @(negedge clk);
        chk("t2_ready_back", 32'(req_ready), 1);
        @(negedge clk);
        chk("t2_mem3", mem[3], 32'h11BB33DD);
        to_drive();

        // 3: back-to-back reads at full rate
        for (int i = 0; i < 8; i++) req(1'b1, AW'(i), 32'hA0000000 + DW'(i), 4'hF);
        pop_cyc.delete(); pop_dat.delete();
        for (int i = 0; i < 8; i++) req(1'b0, AW'(i), 32'h0, 4'h0);
        repeat (6) @(negedge clk);
        chk("t3_count", 32'(pop_cyc.size()), 8);
        for (int i = 0; i < pop_cyc.size(); i++) begin
            chk("t3_data", pop_dat[i], 32'hA0000000 + DW'(i));
            if (i > 0) chk("t3_consecutive", 32'(pop_cyc[i] - pop_cyc[i-1]), 1);
        end
        to_drive();

        // 4: consumer stalled, credits run out, then drain in order
        pop_cyc.delete(); pop_dat.delete();
        n0 = n_rd_acc;
        resp_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) req(1'b0, AW'(i), 32'h0, 4'h0);
            end
            begin
                repeat (6) @(negedge clk);
                chk("t4_accepted", 32'(n_rd_acc - n0), 2);
                chk("t4_ready_low", 32'(req_ready), 0);
                to_drive();
                resp_ready = 1'b1;
            end
        join
        repeat (8) @(negedge clk);
        chk("t4_count", 32'(pop_cyc.size()), 4);
        for (int i = 0; i < pop_dat.size(); i++) chk("t4_data", pop_dat[i], 32'hA0000000 + DW'(i));
        to_drive();

        // 5: zero-strobe write is a nop
        pop_cyc.delete(); pop_dat.delete();
        n0 = n_cmd;
        req(1'b1, 7'd9, 32'hFFFFFFFF, 4'h0);
        repeat (3) @(negedge clk);
        chk("t5_no_cmd", 32'(n_cmd - n0), 0);
        chk("t5_mem9", mem[9], 32'hC0DE0009);
        chk("t5_no_resp", 32'(pop_cyc.size()), 0);
        to_drive();

        // 6: reset lands on the merge cycle
        req(1'b1, 7'd10, 32'h55555555, 4'b0011);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_cmd_in_rst", 32'(bram_cmd_en), 0);
        to_drive();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_cmd_after", 32'(bram_cmd_en), 0);
        chk("t6_wr_after", 32'(bram_wr_en), 0);
        chk("t6_valid_after", 32'(resp_valid), 0);
        chk("t6_ready_after", 32'(req_ready), 1);
        repeat (2) @(negedge clk);
        chk("t6_mem10", mem[10], 32'hC0DE000A);
        to_drive();
        pop_cyc.delete(); pop_dat.delete();
        req(1'b0, 7'd10, 32'h0, 4'h0);
        repeat (4) @(negedge clk);
        chk("t6_read_count", 32'(pop_dat.size()), 1);
        if (pop_dat.size() > 0) chk("t6_read_data", pop_dat[0], 32'hC0DE000A);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
